// File: rtl/led_ctrl.sv
// Multi-channel LED controller: per-channel OFF/ON/BLINK/BURST modes with a
// debounced board switch that re-arms idle burst channels.
module led_ctrl #(
  parameter int NCH     = 2,
  parameter int CNT_W   = 26,
  parameter int DEB_MAX = 500000,
  parameter int BST_W   = 8
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             SW,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [BST_W-1:0] cfg_cnt,
  output logic [NCH-1:0]   led_o,
  output logic [NCH-1:0]   busy_o,
  output logic             sw_db_o
);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_BURST = 2'd3
  } mode_t;

  localparam int DEB_W = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_MAX - 1);

  logic             sync1;
  logic             sw_s;
  logic             sw_db;
  logic             sw_db_d;
  logic             trg;
  logic [DEB_W-1:0] deb_cnt;
  mode_t            new_mode;

  assign new_mode = mode_t'(cfg_mode);
  assign sw_db_o  = sw_db;

  // The debounced level only moves after DEB_MAX consecutive disagreeing cycles;
  // trg is a registered rising-edge detect of that level.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      sync1   <= 1'b0;
      sw_s    <= 1'b0;
      sw_db   <= 1'b0;
      sw_db_d <= 1'b0;
      trg     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1   <= SW;
      sw_s    <= sync1;
      sw_db_d <= sw_db;
      trg     <= sw_db & ~sw_db_d;
      if (sw_s != sw_db) begin
        if (deb_cnt == DEB_LAST) begin
          sw_db   <= sw_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mode_t            mode;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic [BST_W-1:0] rem;
    logic [BST_W-1:0] blen;
    logic             led_r;
    logic             busy_r;
    logic             hit;
    logic             wrap;

    // Indices at or above NCH never match any channel, so such writes vanish.
    assign hit      = cfg_we && (cfg_ch == 3'(g));
    assign wrap     = (cnt == half);
    assign led_o[g]  = led_r;
    assign busy_o[g] = busy_r;

    // A config write takes priority over everything, including a same-cycle retrigger.
    always_ff @(posedge CLK or negedge NRST) begin
      if (!NRST) begin
        mode   <= M_OFF;
        half   <= '0;
        cnt    <= '0;
        rem    <= '0;
        blen   <= '0;
        led_r  <= 1'b0;
        busy_r <= 1'b0;
      end else if (hit) begin
        mode  <= new_mode;
        half  <= cfg_half;
        cnt   <= '0;
        led_r <= (new_mode == M_ON);
        if (new_mode == M_BURST) begin
          rem    <= cfg_cnt;
          blen   <= cfg_cnt;
          busy_r <= (cfg_cnt != '0);
        end else begin
          busy_r <= 1'b0;
        end
      end else begin
        case (mode)
          M_OFF: begin
            led_r <= 1'b0;
            cnt   <= '0;
          end
          M_ON: begin
            led_r <= 1'b1;
            cnt   <= '0;
          end
          M_BLINK: begin
            if (wrap) begin
              cnt   <= '0;
              led_r <= ~led_r;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          M_BURST: begin
            if (busy_r) begin
              if (wrap) begin
                cnt <= '0;
                if (led_r) begin
                  led_r <= 1'b0;
                  rem   <= rem - BST_W'(1);
                  if (rem == BST_W'(1)) begin
                    busy_r <= 1'b0;
                  end
                end else begin
                  led_r <= 1'b1;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else if (trg && (blen != '0)) begin
              rem    <= blen;
              busy_r <= 1'b1;
              cnt    <= '0;
              led_r  <= 1'b0;
            end else begin
              led_r <= 1'b0;
            end
          end
          default: begin
            led_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: elapsed-time behavioural model checked every cycle,
// plus directed literal checks of the key waveforms.
module tb_led_ctrl;

  localparam int NCH     = 2;
  localparam int CNT_W   = 8;
  localparam int DEB_MAX = 4;
  localparam int BST_W   = 8;

  logic             CLK = 1'b0;
  logic             NRST;
  logic             SW;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_half;
  logic [BST_W-1:0] cfg_cnt;
  logic [NCH-1:0]   led_o;
  logic [NCH-1:0]   busy_o;
  logic             sw_db_o;

  int vectors     = 0;
  int miscompares = 0;

  led_ctrl #(
    .NCH(NCH), .CNT_W(CNT_W), .DEB_MAX(DEB_MAX), .BST_W(BST_W)
  ) dut (
    .CLK(CLK), .NRST(NRST), .SW(SW),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_cnt(cfg_cnt),
    .led_o(led_o), .busy_o(busy_o), .sw_db_o(sw_db_o)
  );

  always #5 CLK = ~CLK;

  // Model: each channel tracks the time elapsed since its last start event and
  // derives the LED level and busy flag from that with plain arithmetic.
  int m_mode [NCH];
  int m_half [NCH];
  int m_t    [NCH];
  int m_n    [NCH];
  int m_blen [NCH];
  bit m_act  [NCH];
  bit m_db;
  bit sw_h1, sw_h2;
  bit db_p1, db_p2, db_p3;
  bit m_cmp, m_trg;
  bit win[$];

  function automatic int exp_led(int c);
    int k;
    k = m_t[c] / (m_half[c] + 1);
    case (m_mode[c])
      1:       return 1;
      2:       return k % 2;
      3:       return (m_act[c] && (k % 2 == 1)) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge CLK or negedge NRST);
      if (!NRST) begin
        for (int c = 0; c < NCH; c++) begin
          m_mode[c] = 0; m_half[c] = 0; m_t[c] = 0;
          m_n[c] = 0; m_blen[c] = 0; m_act[c] = 0;
        end
        m_db = 0; sw_h1 = 0; sw_h2 = 0;
        db_p1 = 0; db_p2 = 0; db_p3 = 0;
        win.delete();
      end else begin
        m_trg = db_p2 && !db_p3;
        for (int c = 0; c < NCH; c++) begin
          if (cfg_we && int'(cfg_ch) == c) begin
            m_mode[c] = int'(cfg_mode);
            m_half[c] = int'(cfg_half);
            m_t[c]    = 0;
            if (cfg_mode == 2'd3) begin
              m_n[c] = int'(cfg_cnt); m_blen[c] = int'(cfg_cnt);
              m_act[c] = (cfg_cnt != 0);
            end else begin
              m_act[c] = 0;
            end
          end else begin
            if (m_t[c] < 1000000) m_t[c]++;
            if (m_mode[c] == 3 && m_act[c]) begin
              if (m_t[c] >= 2 * m_n[c] * (m_half[c] + 1)) m_act[c] = 0;
            end else if (m_mode[c] == 3 && m_trg && m_blen[c] != 0) begin
              m_act[c] = 1; m_n[c] = m_blen[c]; m_t[c] = 0;
            end
          end
        end
        m_cmp = sw_h2;
        sw_h2 = sw_h1;
        sw_h1 = SW;
        if (m_cmp != m_db) begin
          win.push_back(m_cmp);
          if (win.size() == DEB_MAX) begin
            m_db = m_cmp;
            win.delete();
          end
        end else begin
          win.delete();
        end
        db_p3 = db_p2; db_p2 = db_p1; db_p1 = m_db;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      for (int c = 0; c < NCH; c++) begin
        checkOutput($sformatf("model_led%0d", c), int'(led_o[c]), exp_led(c));
        checkOutput($sformatf("model_busy%0d", c), int'(busy_o[c]), int'(m_act[c]));
      end
      checkOutput("model_sw_db", int'(sw_db_o), int'(m_db));
    end
  end

  task automatic applyStimulus(input int ch, input int mode, input int half, input int cnt);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_mode = 2'(mode);
    cfg_half = CNT_W'(half);
    cfg_cnt  = BST_W'(cnt);
    @(negedge CLK);
    cfg_we   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    logic [11:0] blink_pat;
    logic [15:0] burst_led, burst_busy;
    blink_pat  = 12'b000011110000;
    burst_led  = 16'b0011001100110000;
    burst_busy = 16'b1111111111110000;

    NRST = 1'b0; SW = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_mode = '0; cfg_half = '0; cfg_cnt = '0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_led", int'(led_o), 0);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_sw_db", int'(sw_db_o), 0);
    NRST = 1'b1;
    @(negedge CLK);

    applyStimulus(0, 1, 0, 0);
    checkOutput("on_led0", int'(led_o[0]), 1);
    checkOutput("on_led1", int'(led_o[1]), 0);
    checkOutput("on_busy", int'(busy_o), 0);

    applyStimulus(1, 2, 3, 0);
    for (int t = 0; t < 12; t++) begin
      checkOutput($sformatf("blink3_t%0d", t), int'(led_o[1]), int'(blink_pat[11-t]));
      @(negedge CLK);
    end
    applyStimulus(1, 2, 0, 0);
    for (int t = 0; t < 3; t++) begin
      checkOutput($sformatf("blink0_t%0d", t), int'(led_o[1]), t % 2);
      @(negedge CLK);
    end

    applyStimulus(0, 3, 1, 0);
    checkOutput("burst0_busy", int'(busy_o[0]), 0);
    repeat (3) @(negedge CLK);
    checkOutput("burst0_led", int'(led_o[0]), 0);

    applyStimulus(0, 3, 1, 3);
    for (int t = 0; t < 16; t++) begin
      checkOutput($sformatf("burst3_led_t%0d", t), int'(led_o[0]), int'(burst_led[15-t]));
      checkOutput($sformatf("burst3_busy_t%0d", t), int'(busy_o[0]), int'(burst_busy[15-t]));
      @(negedge CLK);
    end

    applyStimulus(1, 3, 0, 1);
    checkOutput("ch1_burst_t0_busy", int'(busy_o[1]), 1);
    @(negedge CLK);
    checkOutput("ch1_burst_t1_led", int'(led_o[1]), 1);
    @(negedge CLK);
    checkOutput("ch1_burst_t2_led", int'(led_o[1]), 0);
    checkOutput("ch1_burst_t2_busy", int'(busy_o[1]), 0);

    applyStimulus(5, 1, 7, 9);
    checkOutput("bad_ch_led", int'(led_o), 0);
    checkOutput("bad_ch_busy", int'(busy_o), 0);

    SW = 1'b1;
    repeat (3) @(negedge CLK);
    SW = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge CLK);
      checkOutput($sformatf("glitch_sw_db_%0d", t), int'(sw_db_o), 0);
    end

    SW = 1'b1;
    repeat (5) @(negedge CLK);
    checkOutput("deb_before_rise", int'(sw_db_o), 0);
    @(negedge CLK);
    checkOutput("deb_rise", int'(sw_db_o), 1);
    @(negedge CLK);
    checkOutput("trg_pending_busy", int'(busy_o), 0);
    @(negedge CLK);
    checkOutput("retrig_busy", int'(busy_o), 3);
    checkOutput("retrig_led0_t0", int'(led_o[0]), 0);
    repeat (2) @(negedge CLK);
    checkOutput("retrig_led0_t2", int'(led_o[0]), 1);
    repeat (10) @(negedge CLK);
    checkOutput("retrig_done_busy0", int'(busy_o[0]), 0);

    applyStimulus(0, 3, 7, 3);
    SW = 1'b0;
    repeat (8) @(negedge CLK);
    SW = 1'b1;
    repeat (10) @(negedge CLK);
    checkOutput("second_rise_busy0", int'(busy_o[0]), 1);
    repeat (40) @(negedge CLK);
    checkOutput("long_burst_done", int'(busy_o[0]), 0);

    SW = 1'b0;
    repeat (8) @(negedge CLK);
    checkOutput("deb_fall", int'(sw_db_o), 0);
    SW = 1'b1;
    repeat (7) @(negedge CLK);
    applyStimulus(0, 2, 2, 0);
    checkOutput("cfg_vs_trg_busy", int'(busy_o), 2);
    checkOutput("cfg_vs_trg_led0_t0", int'(led_o[0]), 0);
    repeat (3) @(negedge CLK);
    checkOutput("cfg_vs_trg_led0_t3", int'(led_o[0]), 1);

    applyStimulus(1, 2, 255, 0);
    repeat (255) @(negedge CLK);
    checkOutput("half_max_t255", int'(led_o[1]), 0);
    @(negedge CLK);
    checkOutput("half_max_t256", int'(led_o[1]), 1);

    applyStimulus(0, 3, 3, 2);
    repeat (5) @(negedge CLK);
    checkOutput("pre_reset_led0", int'(led_o[0]), 1);
    checkOutput("pre_reset_busy0", int'(busy_o[0]), 1);
    #2 NRST = 1'b0;
    #1;
    checkOutput("async_reset_led", int'(led_o), 0);
    checkOutput("async_reset_busy", int'(busy_o), 0);
    checkOutput("async_reset_sw_db", int'(sw_db_o), 0);
    repeat (2) @(negedge CLK);
    #2 NRST = 1'b1;
    repeat (4) @(negedge CLK);
    checkOutput("post_reset_led", int'(led_o), 0);
    checkOutput("post_reset_busy", int'(busy_o), 0);
    repeat (6) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
